// File: rtl/smc_wr_strobe_seq_lite.sv
// smc_wr_strobe_seq_lite
// Runs one SETUP / STROBE / HOLD write-strobe sequence for each accepted request
// and drives the active-low byte/write strobes into the write-enable gating stage.
//
// Handshake: a request is accepted on the rising edge where wr_req and wr_ready
// are both high. wr_ready is high exactly when the sequencer is IDLE. The
// requester keeps wr_req, wr_be and cfg_* stable until that edge, and anything
// it drives afterwards is ignored until the next acceptance.
module smc_wr_strobe_seq_lite #(
    parameter int CNT_W = 4
) (
    input  logic             hclk,
    input  logic             sys_reset,
    input  logic             wr_req,
    input  logic [3:0]       wr_be,
    input  logic [CNT_W-1:0] cfg_ws_setup,
    input  logic [CNT_W-1:0] cfg_ws_strobe,
    input  logic [CNT_W-1:0] cfg_ws_hold,
    output logic             wr_ready,
    output logic             wr_done,
    output logic             r_full,
    output logic [3:0]       n_r_we,
    output logic             n_r_wr,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       be_q, be_nxt;
    // The setup count is consumed directly into the counter on acceptance,
    // so only the strobe and hold counts need holding registers.
    logic [CNT_W-1:0] strobe_q, strobe_nxt;
    logic [CNT_W-1:0] hold_q, hold_nxt;
    logic             done_nxt;
    logic             strobe_on;

    // Next-state, counter and latch decode for the sequencer.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        be_nxt     = be_q;
        strobe_nxt = strobe_q;
        hold_nxt   = hold_q;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (wr_req) begin
                    be_nxt     = wr_be;
                    strobe_nxt = cfg_ws_strobe;
                    hold_nxt   = cfg_ws_hold;
                    if (cfg_ws_setup != '0) begin
                        state_nxt = SETUP;
                        cnt_nxt   = cfg_ws_setup - CNT_ONE;
                    end else begin
                        state_nxt = STROBE;
                        cnt_nxt   = cfg_ws_strobe;
                    end
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = STROBE;
                    cnt_nxt   = strobe_q;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    if (hold_q != '0) begin
                        state_nxt = HOLD;
                        cnt_nxt   = hold_q - CNT_ONE;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobe outputs are decoded from the next state so the flops switch cleanly.
    always_comb begin
        strobe_on = (state_nxt == STROBE);
    end

    // Sequencer state, counter, latched request and registered strobe outputs.
    always_ff @(posedge hclk or posedge sys_reset) begin
        if (sys_reset) begin
            state    <= IDLE;
            cnt      <= '0;
            be_q     <= '0;
            strobe_q <= '0;
            hold_q   <= '0;
            wr_done  <= 1'b0;
            r_full   <= 1'b0;
            n_r_we   <= 4'b1111;
            n_r_wr   <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            be_q     <= be_nxt;
            strobe_q <= strobe_nxt;
            hold_q   <= hold_nxt;
            wr_done  <= done_nxt;
            r_full   <= strobe_on;
            n_r_we   <= strobe_on ? ~be_nxt : 4'b1111;
            n_r_wr   <= ~strobe_on;
        end
    end

    // Ready and debug state follow the state register directly.
    always_comb begin
        wr_ready  = (state == IDLE);
        state_dbg = state;
    end

endmodule

// File: tb/tb_smc_wr_strobe_seq_lite.sv
// tb_smc_wr_strobe_seq_lite
// Directed bench for the write-strobe sequencer. Outputs are sampled on the
// falling edge; inputs are driven right after that falling edge.
module tb_smc_wr_strobe_seq_lite;

    logic       hclk;
    logic       sys_reset;
    logic       wr_req;
    logic [3:0] wr_be;
    logic [3:0] cfg_ws_setup;
    logic [3:0] cfg_ws_strobe;
    logic [3:0] cfg_ws_hold;
    logic       wr_ready;
    logic       wr_done;
    logic       r_full;
    logic [3:0] n_r_we;
    logic       n_r_wr;
    logic [1:0] state_dbg;

    int errors = 0;
    int checks = 0;

    smc_wr_strobe_seq_lite #(.CNT_W(4)) dut (
        .hclk          (hclk),
        .sys_reset     (sys_reset),
        .wr_req        (wr_req),
        .wr_be         (wr_be),
        .cfg_ws_setup  (cfg_ws_setup),
        .cfg_ws_strobe (cfg_ws_strobe),
        .cfg_ws_hold   (cfg_ws_hold),
        .wr_ready      (wr_ready),
        .wr_done       (wr_done),
        .r_full        (r_full),
        .n_r_we        (n_r_we),
        .n_r_wr        (n_r_wr),
        .state_dbg     (state_dbg)
    );

    // Clock: 10 ns period.
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Compares {wr_ready, wr_done, r_full, n_r_we, n_r_wr} in one go.
    task automatic expect_out(input string tag, input logic rdy, input logic done,
                              input logic full, input logic [3:0] we, input logic wr);
        check(tag, {wr_ready, wr_done, r_full, n_r_we, n_r_wr}, {rdy, done, full, we, wr});
    endtask

    task automatic next_cycle();
        @(negedge hclk);
    endtask

    // Present a request at the falling edge; the following rising edge is edge k.
    // Returns in cycle k+1 with wr_req dropped.
    task automatic issue(input logic [3:0] be, input logic [3:0] s,
                         input logic [3:0] t, input logic [3:0] h);
        wr_be         = be;
        cfg_ws_setup  = s;
        cfg_ws_strobe = t;
        cfg_ws_hold   = h;
        wr_req        = 1'b1;
        next_cycle();
        wr_req = 1'b0;
    endtask

    initial begin
        sys_reset     = 1'b1;
        wr_req        = 1'b0;
        wr_be         = 4'h0;
        cfg_ws_setup  = 4'd0;
        cfg_ws_strobe = 4'd0;
        cfg_ws_hold   = 4'd0;
        next_cycle();
        expect_out("por_outputs", 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1);
        check("por_state", {6'd0, state_dbg}, 8'd0);
        sys_reset = 1'b0;
        next_cycle();

        // T1: reset asserted mid-clock while idle
        #2 sys_reset = 1'b1;
        #1 expect_out("t1_async_reset", 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1);
        next_cycle();
        sys_reset = 1'b0;
        next_cycle();

        // T2: S=1 T=2 H=1 be=0101
        issue(4'b0101, 4'd1, 4'd2, 4'd1);
        expect_out("t2_setup_k1", 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1);
        check("t2_state_setup", {6'd0, state_dbg}, 8'd1);
        for (int i = 2; i <= 4; i++) begin
            next_cycle();
            expect_out($sformatf("t2_strobe_k%0d", i), 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0);
        end
        next_cycle();
        expect_out("t2_hold_k5", 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1);
        check("t2_state_hold", {6'd0, state_dbg}, 8'd3);
        next_cycle();
        expect_out("t2_done_k6", 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1);
        next_cycle();
        expect_out("t2_idle_k7", 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1);

        // T3: all zero counts, be=F
        issue(4'hF, 4'd0, 4'd0, 4'd0);
        expect_out("t3_strobe_k1", 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
        next_cycle();
        expect_out("t3_done_k2", 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1);
        next_cycle();
        expect_out("t3_idle_k3", 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1);

        // T4: back-to-back with wr_req held high, S=0 T=1 H=0 be=0011
        wr_be         = 4'b0011;
        cfg_ws_setup  = 4'd0;
        cfg_ws_strobe = 4'd1;
        cfg_ws_hold   = 4'd0;
        wr_req        = 1'b1;
        next_cycle();
        expect_out("t4_strobe_k1", 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0);
        next_cycle();
        expect_out("t4_strobe_k2", 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0);
        next_cycle();
        expect_out("t4_done_k3", 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1);
        next_cycle();
        expect_out("t4_strobe_k4", 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0);
        next_cycle();
        expect_out("t4_strobe_k5", 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0);
        next_cycle();
        expect_out("t4_done_k6", 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1);
        wr_req = 1'b0;
        next_cycle();
        expect_out("t4_idle_k7", 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1);

        // T5: reset in the middle of a 4-cycle strobe
        issue(4'b1001, 4'd0, 4'd3, 4'd0);
        next_cycle();
        expect_out("t5_strobe_k2", 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0);
        #2 sys_reset = 1'b1;
        #1 expect_out("t5_reset_now", 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1);
        next_cycle();
        sys_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            expect_out($sformatf("t5_no_done_%0d", i), 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1);
        end
        issue(4'b1000, 4'd0, 4'd0, 4'd1);
        expect_out("t5_after_strobe", 1'b0, 1'b0, 1'b1, 4'b0111, 1'b0);
        next_cycle();
        expect_out("t5_after_hold", 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1);
        next_cycle();
        expect_out("t5_after_done", 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1);

        // T6a: inputs change during SETUP, latched values must be used
        issue(4'b0110, 4'd2, 4'd1, 4'd1);
        wr_be         = 4'b1111;
        cfg_ws_setup  = 4'd0;
        cfg_ws_strobe = 4'd0;
        cfg_ws_hold   = 4'd0;
        expect_out("t6a_setup_k1", 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1);
        next_cycle();
        expect_out("t6a_setup_k2", 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1);
        next_cycle();
        expect_out("t6a_strobe_k3", 1'b0, 1'b0, 1'b1, 4'b1001, 1'b0);
        next_cycle();
        expect_out("t6a_strobe_k4", 1'b0, 1'b0, 1'b1, 4'b1001, 1'b0);
        next_cycle();
        expect_out("t6a_hold_k5", 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1);
        next_cycle();
        expect_out("t6a_done_k6", 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1);

        // T6b: be=0 with all-max counts: 15 setup, 16 strobe, 15 hold, done at k+47
        issue(4'b0000, 4'd15, 4'd15, 4'd15);
        for (int i = 1; i <= 15; i++) begin
            if (i > 1) next_cycle();
            expect_out($sformatf("t6b_setup_k%0d", i), 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1);
        end
        for (int i = 16; i <= 31; i++) begin
            next_cycle();
            expect_out($sformatf("t6b_strobe_k%0d", i), 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
        end
        for (int i = 32; i <= 46; i++) begin
            next_cycle();
            expect_out($sformatf("t6b_hold_k%0d", i), 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1);
        end
        next_cycle();
        expect_out("t6b_done_k47", 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1);
        next_cycle();
        expect_out("t6b_idle_k48", 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
